rs232_rx_fsm: RTL and testbench

Receive-side control stage for the RS232 receiver: detects the start bit on the serial line, times each bit with an internal bit-timing counter, samples the data bits at mid-bit and checks the stop bit. Presents each received byte on a parallel bus with a one-cycle strobe. Sits between the raw `rx` pin and the consumer logic (display or register bank); it is the only stage that interprets the line.

---
 rtl/rs232_rx_pkg.sv | 16 +
 rtl/rs232_rx_fsm_timer.sv | 30 +++
 rtl/rs232_rx_fsm.sv | 174 +++++++++++++++++
 tb/tb_rs232_rx_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rs232_rx_pkg.sv
// rs232_rx_pkg: shared state encoding and default sizes for the RS232 receiver.
// Optional parity support in the receiver is enabled with RX_PARITY_EN.
package rs232_rx_pkg;

    localparam int DEF_WIDTH     = 15;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rs232_rx_fsm_timer.sv
// rx_bit_timer: clearable bit-period counter with a combinational terminal flag.
// Counts 0..term_i while enabled, then wraps to 0.
module rx_bit_timer
    import rs232_rx_pkg::*;
#(
    parameter int Width = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             term_o
);

    logic [Width-1:0] r_cnt;

    assign term_o = (r_cnt == term_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= term_o ? '0 : r_cnt + Width'(1);
        end
    end

endmodule

// File: rtl/rs232_rx_fsm.sv
// rs232_rx_fsm: RS232 receive control - start detect, mid-bit sampling, stop check.
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module rs232_rx_fsm
    import rs232_rx_pkg::*;
#(
    parameter int Width    = DEF_WIDTH,
    parameter int DataBits = DEF_DATA_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_i,
    input  logic [Width-1:0]    baud_max_i,
    output logic [DataBits-1:0] data_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                frame_err_o,
    output logic                parity_err_o
);

    localparam int BW = $clog2(DataBits + 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_hist;
    rx_state_e           r_state;
    rx_state_e           w_next;
    logic [DataBits-1:0] r_shift;
    logic [DataBits-1:0] r_data;
    logic [BW-1:0]       r_bits;
    logic                r_valid;
    logic                r_ferr;
    logic                w_clr;
    logic                w_en;
    logic                w_half;
    logic                w_term;
    logic                w_shift;
    logic                w_stop;
    logic                w_last;
    logic [Width-1:0]    w_tval;
`ifdef RX_PARITY_EN
    logic                w_par;
    logic                r_pbad;
    logic                r_perr;
`endif

    // 2-flop synchronizer plus history flop; idle-high reset avoids a false edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_tval = w_half ? (baud_max_i >> 1) : baud_max_i;
    assign w_last = (r_bits == BW'(DataBits - 1));

    rx_bit_timer #(
        .Width (Width)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_clr),
        .en_i   (w_en),
        .term_i (w_tval),
        .term_o (w_term)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_en    = 1'b0;
        w_half  = 1'b0;
        w_shift = 1'b0;
        w_stop  = 1'b0;
`ifdef RX_PARITY_EN
        w_par   = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (r_hist && !r_sync2) w_next = ST_START;
            end
            ST_START: begin
                w_en   = 1'b1;
                w_half = 1'b1;
                if (w_term) w_next = r_sync2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                w_en = 1'b1;
                if (w_term) begin
                    w_shift = 1'b1;
`ifdef RX_PARITY_EN
                    if (w_last) w_next = ST_PARITY;
`else
                    if (w_last) w_next = ST_STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                w_en = 1'b1;
                if (w_term) begin
                    w_par  = 1'b1;
                    w_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                w_en = 1'b1;
                if (w_term) begin
                    w_stop = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift <= '0;
            r_bits  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
            r_pbad  <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
            r_perr  <= 1'b0;
            if (w_par) r_pbad <= (r_sync2 != ^r_shift);
`endif
            if (r_state != ST_DATA) r_bits <= '0;
            else if (w_shift)       r_bits <= r_bits + BW'(1);
            if (w_shift) r_shift <= {r_sync2, r_shift[DataBits-1:1]};
            if (w_stop) begin
                if (r_sync2) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
`ifdef RX_PARITY_EN
                    r_perr  <= r_pbad;
`endif
                end else begin
                    r_ferr  <= 1'b1;
                end
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != ST_IDLE);
`ifdef RX_PARITY_EN
    assign parity_err_o = r_perr;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx_fsm.sv
// tb_rs232_rx_fsm: directed vector bench for rs232_rx_fsm with M=4 (5 clocks/bit).
// Parity expectations follow RX_PARITY_EN when it is defined for the build.
module tb_rs232_rx_fsm;

    localparam int W  = 15;
    localparam int DB = 8;
    localparam int M  = 4;
    localparam int BP = M + 1;
`ifdef RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [W-1:0]  baud = W'(M);
    logic [DB-1:0] data;
    logic          valid;
    logic          busy;
    logic          ferr;
    logic          perr;

    rs232_rx_fsm #(
        .Width    (W),
        .DataBits (DB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .baud_max_i   (baud),
        .data_o       (data),
        .valid_o      (valid),
        .busy_o       (busy),
        .frame_err_o  (ferr),
        .parity_err_o (perr)
    );

    always #5 clk = ~clk;

    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_overlap = 0;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vq.push_back(data);
            if (busy) n_overlap++;
        end
        if (ferr) begin
            n_ferr++;
            if (busy) n_overlap++;
        end
        if (perr) n_perr++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BP) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic p);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PAR) drive_bit(p);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        stop;
        logic        par;
        logic [31:0] ev;
        logic [31:0] ef;
        logic [31:0] ep;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, f0, p0;
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5};
        tbl[2] = '{8'h81, 1'b1, 1'b0, 1, 0, 0, 8'h81};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 1, 0, PAR ? 1 : 0, 8'h01};
        tbl[4] = '{8'h01, 1'b1, 1'b1, 1, 0, 0, 8'h01};
        tbl[5] = '{8'h7E, 1'b0, 1'b0, 0, 1, 0, 8'h01};

        repeat (3) tick();
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_perr", perr, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr;
            send_frame(tbl[k].d, tbl[k].stop, tbl[k].par);
            rx = 1'b1;
            repeat (12) tick();
            chk($sformatf("vec%0d_valid", k), n_valid - v0, tbl[k].ev);
            chk($sformatf("vec%0d_ferr", k), n_ferr - f0, tbl[k].ef);
            chk($sformatf("vec%0d_perr", k), n_perr - p0, tbl[k].ep);
            chk($sformatf("vec%0d_data", k), data, tbl[k].ed);
            chk($sformatf("vec%0d_busy", k), busy, 0);
        end

        // start glitch: low for 2 clocks; START seen 3 clocks after the edge
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        tick();
        chk("lat_busy_c1", busy, 0);
        tick();
        rx = 1'b1;
        chk("lat_busy_c2", busy, 0);
        tick();
        chk("lat_busy_c3", busy, 1);
        repeat (10) tick();
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", n_valid - v0, 0);
        chk("glitch_ferr", n_ferr - f0, 0);
        chk("glitch_data", data, 8'h01);

        // break: line held low after a framing error yields nothing more
        f0 = n_ferr; v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (30) tick();
        chk("break_busy", busy, 0);
        chk("break_ferr", n_ferr - f0, 1);
        chk("break_valid", n_valid - v0, 0);
        rx = 1'b1;
        repeat (10) tick();
        chk("break_busy_after", busy, 0);

        // back-to-back frames with no idle gap
        v0 = n_valid;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (12) tick();
        chk("b2b_count", n_valid - v0, 2);
        if (vq.size() >= 2) begin
            chk("b2b_first", vq[vq.size()-2], 8'h00);
            chk("b2b_second", vq[vq.size()-1], 8'hFF);
        end else begin
            chk("b2b_queue", vq.size(), 2);
        end
        chk("b2b_data", data, 8'hFF);

        // reset during data bit 3 of 0x33
        v0 = n_valid; f0 = n_ferr;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (2) tick();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ferr", ferr, 0);
        chk("mid_rst_perr", perr, 0);
        repeat (2) tick();
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_no_strobe", (n_valid - v0) + (n_ferr - f0), 0);
        v0 = n_valid;
        send_frame(8'h5A, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (12) tick();
        chk("post_rst_valid", n_valid - v0, 1);
        chk("post_rst_data", data, 8'h5A);

        chk("busy_at_strobe", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
